// File: rtl/fpu_out_arb_rr.sv
// Result-return arbiter onto the CPX request port: pipe 0 has priority, the
// other pipes share round-robin priority, with credit flow control and a starvation bound.
module fpu_out_arb_rr #(
  parameter int NPIPE   = 3,
  parameter int ID_W    = 10,
  parameter int CREDITS = 2,
  parameter int MAXHI   = 4
) (
  input  logic                  rclk,
  input  logic                  grst_l,
  input  logic [NPIPE-1:0]      req_vld,
  input  logic [NPIPE*ID_W-1:0] req_id,
  output logic [NPIPE-1:0]      req_rdy,
  input  logic                  cpx_fp_grant,
  output logic [ID_W-3:0]       fp_cpx_req_cq,
  output logic [1:0]            req_thread,
  output logic [NPIPE-1:0]      dest_rdy,
  output logic                  out_vld,
  output logic [3:0]            credit_cnt
);

  localparam int PW = $clog2(NPIPE);
  localparam int HW = $clog2(MAXHI + 1);

  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [HW-1:0]   hi_cnt, hi_nxt;
  logic [3:0]      cred_nxt;
  logic [ID_W-1:0] sel_id;
  logic            issue, lp, xfer, found;
  int              k;

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    req_rdy  = '0;
    rr_nxt   = rr_ptr;
    hi_nxt   = hi_cnt;
    sel_id   = '0;
    found    = 1'b0;
    k        = 0;
    issue    = (credit_cnt != 4'd0);
    lp       = |req_vld[NPIPE-1:1];

    if (issue) begin
      if (req_vld[0] && !(lp && hi_cnt == HW'(MAXHI))) begin
        req_rdy[0] = 1'b1;
      end else begin
        // Search the low pipes starting at rr_ptr, wrapping NPIPE-1 -> 1.
        for (int off = 0; off < NPIPE - 1; off++) begin
          k = int'(rr_ptr) + off;
          if (k > NPIPE - 1) k = k - (NPIPE - 1);
          if (!found && req_vld[k]) begin
            found      = 1'b1;
            req_rdy[k] = 1'b1;
            rr_nxt     = (k == NPIPE - 1) ? PW'(1) : PW'(k + 1);
          end
        end
      end
    end

    if (!lp || found) begin
      hi_nxt = '0;
    end else if (req_rdy[0] && hi_cnt != HW'(MAXHI)) begin
      hi_nxt = hi_cnt + HW'(1);
    end

    xfer = |req_rdy;
    for (int i = 0; i < NPIPE; i++) begin
      if (req_rdy[i]) sel_id = req_id[i*ID_W +: ID_W];
    end

    cred_nxt = credit_cnt;
    if (xfer && !cpx_fp_grant) begin
      cred_nxt = credit_cnt - 4'd1;
    end else if (!xfer && cpx_fp_grant && credit_cnt != 4'(CREDITS)) begin
      cred_nxt = credit_cnt + 4'd1;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // the same pre-edge values.
  always_ff @(posedge rclk) begin
    if (!grst_l) begin
      fp_cpx_req_cq <= '0;
      req_thread    <= '0;
      dest_rdy      <= '0;
      out_vld       <= 1'b0;
      credit_cnt    <= 4'(CREDITS);
      rr_ptr        <= PW'(1);
      hi_cnt        <= '0;
    end else begin
      // With no transfer sel_id is zero, so the data fields clear as well.
      fp_cpx_req_cq <= sel_id[ID_W-1:2];
      req_thread    <= sel_id[1:0];
      dest_rdy      <= req_rdy;
      out_vld       <= xfer;
      credit_cnt    <= cred_nxt;
      rr_ptr        <= rr_nxt;
      hi_cnt        <= hi_nxt;
    end
  end

endmodule

// File: tb/tb_fpu_out_arb_rr.sv
// Scoreboard bench for fpu_out_arb_rr: a request-level model predicts grants
// and credits; a monitor pops expected results whenever out_vld is seen.
module tb_fpu_out_arb_rr;
  localparam int NPIPE   = 3;
  localparam int ID_W    = 10;
  localparam int CREDITS = 2;
  localparam int MAXHI   = 4;

  logic                  rclk = 1'b0;
  logic                  grst_l = 1'b0;
  logic [NPIPE-1:0]      req_vld = '0;
  logic [NPIPE*ID_W-1:0] req_id = '0;
  logic [NPIPE-1:0]      req_rdy;
  logic                  cpx_fp_grant = 1'b0;
  logic [ID_W-3:0]       fp_cpx_req_cq;
  logic [1:0]            req_thread;
  logic [NPIPE-1:0]      dest_rdy;
  logic                  out_vld;
  logic [3:0]            credit_cnt;

  fpu_out_arb_rr #(.NPIPE(NPIPE), .ID_W(ID_W), .CREDITS(CREDITS), .MAXHI(MAXHI)) dut (
    .rclk(rclk), .grst_l(grst_l), .req_vld(req_vld), .req_id(req_id), .req_rdy(req_rdy),
    .cpx_fp_grant(cpx_fp_grant), .fp_cpx_req_cq(fp_cpx_req_cq), .req_thread(req_thread),
    .dest_rdy(dest_rdy), .out_vld(out_vld), .credit_cnt(credit_cnt)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [NPIPE-1:0] dest;
    logic [ID_W-1:0]  id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  // Reference model: available credits, the last low pipe served, and the
  // length of the current run of pipe-0 wins made while a low pipe waited.
  int   m_cred;
  int   m_last_low;
  int   m_streak;

  bit              pend_v  [NPIPE];
  logic [ID_W-1:0] pend_id [NPIPE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic model_reset();
    m_cred     = CREDITS;
    m_last_low = NPIPE - 1;
    m_streak   = 0;
  endtask

  // One cycle: drive at posedge+1, predict and check at negedge.
  task automatic apply(input bit gnt, input bit rst);
    int               winner;
    int               p;
    bit               lp;
    logic [NPIPE-1:0] exp_rdy;
    for (int i = 0; i < NPIPE; i++) begin
      req_vld[i]               = pend_v[i];
      req_id[i*ID_W +: ID_W]   = pend_id[i];
    end
    cpx_fp_grant = gnt;
    grst_l       = !rst;
    @(negedge rclk);

    lp = 1'b0;
    for (int i = 1; i < NPIPE; i++) lp |= pend_v[i];
    winner = -1;
    if (m_cred > 0) begin
      if (pend_v[0] && !(lp && m_streak >= MAXHI)) begin
        winner = 0;
      end else begin
        for (int j = 1; j < NPIPE; j++) begin
          p = ((m_last_low - 1 + j) % (NPIPE - 1)) + 1;
          if (winner < 0 && pend_v[p]) winner = p;
        end
      end
    end
    exp_rdy = '0;
    if (winner >= 0) exp_rdy[winner] = 1'b1;
    check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    check("credit_cnt", 32'(credit_cnt), 32'(m_cred));

    if (rst) begin
      model_reset();
    end else begin
      if (winner >= 0) exp_q.push_back('{dest: exp_rdy, id: pend_id[winner]});
      if (winner == 0)     m_streak = lp ? ((m_streak < MAXHI) ? m_streak + 1 : MAXHI) : 0;
      else if (winner > 0) begin m_last_low = winner; m_streak = 0; end
      else if (!lp)        m_streak = 0;
      if (winner >= 0 && !gnt)                 m_cred--;
      else if (winner < 0 && gnt && m_cred < CREDITS) m_cred++;
    end
    if (winner >= 0) pend_v[winner] = 1'b0;
    @(posedge rclk);
    #1;
  endtask

  task automatic phase(input logic [NPIPE-1:0] mask, input int vld_pct, input int gnt_pct,
                       input int rst_pct, input int n);
    logic [31:0] r;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NPIPE; i++) begin
        if (mask[i] && !pend_v[i] && ($urandom % 100) < vld_pct) begin
          r          = $urandom;
          pend_v[i]  = 1'b1;
          pend_id[i] = r[ID_W-1:0];
        end
      end
      apply(($urandom % 100) < gnt_pct, ($urandom % 100) < rst_pct);
    end
  endtask

  // Monitor: runs independently of the stimulus, one sample per cycle.
  always begin
    @(posedge rclk);
    #1;
    if (mon_en) begin
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_vld", 32'(out_vld), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("dest_rdy", 32'(dest_rdy), 32'(mon_e.dest));
          check("req_thread", 32'(req_thread), 32'(mon_e.id[1:0]));
          check("fp_cpx_req_cq", 32'(fp_cpx_req_cq), 32'(mon_e.id[ID_W-1:2]));
        end
      end else begin
        check("idle_fields", 32'({dest_rdy, req_thread, fp_cpx_req_cq}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NPIPE; i++) begin
      pend_v[i]  = 1'b0;
      pend_id[i] = '0;
    end
    model_reset();

    // Reset for two cycles, then idle.
    apply(1'b0, 1'b1);
    mon_en = 1'b1;
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b0);

    // Single request on pipe 1: thread 3, code 8'hA9.
    pend_v[1]  = 1'b1;
    pend_id[1] = 10'h2A7;
    apply(1'b0, 1'b0);
    apply(1'b0, 1'b0);

    // Round-robin between pipes 1 and 2 with a grant every cycle.
    phase(3'b110, 100, 100, 0, 8);
    // Starvation guard with all pipes busy.
    phase(3'b111, 100, 100, 0, 12);
    // Drain and refill credits, then exhaust them with pipe 1.
    phase(3'b000, 0, 100, 0, 4);
    phase(3'b010, 100, 0, 0, 5);
    phase(3'b010, 100, 100, 0, 1);
    phase(3'b010, 100, 0, 0, 3);
    // Grant plus transfer together, then spurious grants at full credit.
    phase(3'b010, 100, 100, 0, 3);
    phase(3'b000, 0, 100, 0, 4);
    // Reset while a transfer is pending.
    pend_v[2]  = 1'b1;
    pend_id[2] = 10'h155;
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b0);

    // Randomised traffic with occasional resets.
    phase(3'b111, 40, 50, 2, 300);
    phase(3'b111, 80, 30, 0, 100);
    phase(3'b000, 0, 100, 0, 20);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
